rr_int_coalescer: RTL and testbench
===================================

RR_INT_COALESCER -- requirements
Module: rr_int_coalescer

Interface
REQ-001 SHALL have parameter NUM_INT, default 16: number of interrupt channels.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: per-channel event counter width.
REQ-003 SHALL have parameter TMO_WIDTH, default 32: timeout timer width.
REQ-004 SHALL have port clk  input  1: clock; all logic on posedge.
REQ-005 SHALL have port rstn  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port enable  input  1: 1 allows new requests; 0 blocks firing.
REQ-007 SHALL have port threshold  input  CNT_WIDTH: event count that triggers a request; 0 is treated as 1.
REQ-008 SHALL have port timeout  input  TMO_WIDTH: cycles in ACCUM before a forced request; 0 disables timeout.
REQ-009 SHALL have port ev  input  NUM_INT: per-channel event pulse, one event per set bit per cycle.
REQ-010 SHALL have port int_req  output  NUM_INT: per-channel single-cycle request pulse to the downstream interrupt-to-PCIM writer.
REQ-011 SHALL have port int_ack  input  NUM_INT: per-channel single-cycle completion pulse from the writer.
REQ-012 SHALL have port inflight  output  NUM_INT: 1 while the channel is in WAIT_ACK.
REQ-013 SHALL have port ovf  output  NUM_INT: sticky per-channel counter-saturation flag.

Function
REQ-014 SHALL keep independent per-channel state: FSM {IDLE, ACCUM, WAIT_ACK}, count[CNT_WIDTH], timer[TMO_WIDTH].
REQ-015 IDLE: ev[i] -> ACCUM, count=1, timer=0.
REQ-016 ACCUM: timer +1 per cycle (saturating); count +1 per ev[i] (saturating at all-ones, sets ovf[i]).
REQ-017 Fire condition in ACCUM: enable=1 and (count_next >= max(threshold,1) or (timeout!=0 and timer_next >= timeout)).
REQ-018 On a fire edge: int_req[i] SHALL be registered high for exactly the following cycle; count and timer cleared to 0; state -> WAIT_ACK.
REQ-019 Latency: the event completing the threshold, sampled on edge N, SHALL give int_req[i]=1 during the cycle after edge N.
REQ-020 Timeout: ACCUM entered on edge E with no further events SHALL fire on edge E+timeout.
REQ-021 WAIT_ACK: ev[i] increments count (saturating); timer held at 0; no further int_req[i].
REQ-022 WAIT_ACK + int_ack[i]: count_next>0 -> ACCUM with timer=0; else -> IDLE.
REQ-023 int_ack[i] in IDLE or ACCUM SHALL be ignored.
REQ-024 ev[i] on a fire edge SHALL not be lost: count=1 entering WAIT_ACK.
REQ-025 enable=0: ACCUM keeps counting with timer saturating; no fire; WAIT_ACK still completes on ack; firing resumes on the first edge with enable=1 if the condition holds.
REQ-026 Multiple channels MAY fire on the same edge; int_req bits are independent.
REQ-027 threshold/timeout changes SHALL take effect on the next compare and SHALL not clear count or timer.
REQ-028 ovf[i] SHALL clear only on reset.

Reset
REQ-029 rstn=0 on an edge SHALL set all channels to IDLE, count=0, timer=0, int_req=0, inflight=0, ovf=0, including mid-WAIT_ACK; acks received after reset are ignored per REQ-023.

Verification
REQ-030 threshold=4, timeout=0, ev[3] on 4 consecutive cycles -> int_req=16'h0008 for one cycle after the 4th event edge; inflight[3]=1 until int_ack[3].
REQ-031 threshold=100, timeout=10, single ev[0] on edge E -> int_req[0] pulse after edge E+10; count cleared.
REQ-032 Channel 5 in WAIT_ACK, 3 ev[5] pulses, then int_ack[5] -> ACCUM with count=3; with threshold=3 it fires on the next edge.
REQ-033 ev[2] on the fire edge -> WAIT_ACK count=1; ack -> ACCUM, not IDLE.
REQ-034 CNT_WIDTH=4, enable=0, 20 ev[1] -> count=15, ovf[1]=1, no int_req; enable=1 -> fire next edge.
REQ-035 rstn=0 while channels 0 and 7 are in WAIT_ACK -> all outputs 0; a later int_ack=16'h0081 produces no state change.

Source files
------------

// File: rtl/rr_int_coalescer.sv
// Per-channel interrupt coalescer: counts events and raises one request per
// batch, either at the count threshold or after a timeout, then waits for ack.
module rr_int_coalescer #(
  parameter int NUM_INT   = 16,
  parameter int CNT_WIDTH = 16,
  parameter int TMO_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] threshold,
  input  logic [TMO_WIDTH-1:0] timeout,
  input  logic [NUM_INT-1:0]   ev,
  output logic [NUM_INT-1:0]   int_req,
  input  logic [NUM_INT-1:0]   int_ack,
  output logic [NUM_INT-1:0]   inflight,
  output logic [NUM_INT-1:0]   ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, WAIT_ACK} state_t;

  // A zero threshold behaves like one so a channel can never stall in ACCUM.
  logic [CNT_WIDTH-1:0] thr_eff;
  logic                 tmo_en;

  assign thr_eff = (threshold == '0) ? CNT_WIDTH'(1) : threshold;
  assign tmo_en  = (timeout != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INT; gi++) begin : g_ch
      state_t               state_reg, state_next;
      logic [CNT_WIDTH-1:0] count_reg, count_next, count_inc;
      logic [TMO_WIDTH-1:0] timer_reg, timer_next, timer_inc;
      logic                 req_reg, req_next;
      logic                 ovf_reg, ovf_next;
      logic                 fire;

      always_comb begin
        count_inc  = (count_reg == '1) ? count_reg : count_reg + 1'b1;
        timer_inc  = (timer_reg == '1) ? timer_reg : timer_reg + 1'b1;
        state_next = state_reg;
        count_next = count_reg;
        timer_next = timer_reg;
        req_next   = 1'b0;
        ovf_next   = ovf_reg;
        fire       = 1'b0;
        case (state_reg)
          IDLE: begin
            if (ev[gi]) begin
              state_next = ACCUM;
              count_next = CNT_WIDTH'(1);
              timer_next = '0;
            end
          end
          ACCUM: begin
            timer_next = timer_inc;
            if (ev[gi]) begin
              count_next = count_inc;
              if (count_reg == '1) ovf_next = 1'b1;
            end
            fire = enable && ((count_next >= thr_eff) ||
                              (tmo_en && (timer_next >= timeout)));
            if (fire) begin
              req_next   = 1'b1;
              state_next = WAIT_ACK;
              // An event landing on the fire edge starts the next batch.
              count_next = {{(CNT_WIDTH-1){1'b0}}, ev[gi]};
              timer_next = '0;
            end
          end
          WAIT_ACK: begin
            timer_next = '0;
            if (ev[gi]) begin
              count_next = count_inc;
              if (count_reg == '1) ovf_next = 1'b1;
            end
            if (int_ack[gi]) state_next = (count_next != '0) ? ACCUM : IDLE;
          end
          default: state_next = IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rstn) begin
          state_reg <= IDLE;
          count_reg <= '0;
          timer_reg <= '0;
          req_reg   <= 1'b0;
          ovf_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          count_reg <= count_next;
          timer_reg <= timer_next;
          req_reg   <= req_next;
          ovf_reg   <= ovf_next;
        end
      end

      assign int_req[gi]  = req_reg;
      assign inflight[gi] = (state_reg == WAIT_ACK);
      assign ovf[gi]      = ovf_reg;
    end
  endgenerate

endmodule

// File: tb/tb_rr_int_coalescer.sv
// Directed scoreboard bench: each step pushes the outputs expected after its
// edge; a negedge monitor pops and compares them against both DUT instances.
module tb_rr_int_coalescer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [15:0] threshold;
  logic [31:0] timeout;
  logic [15:0] ev, int_ack;
  logic [15:0] int_req, inflight, ovf;

  logic [3:0]  threshold4;
  logic [31:0] timeout4;
  logic [15:0] ev4, int_ack4;
  logic [15:0] int_req4, inflight4, ovf4;

  always #5 clk = ~clk;

  rr_int_coalescer dut (
    .clk(clk), .rstn(rstn), .enable(enable), .threshold(threshold),
    .timeout(timeout), .ev(ev), .int_req(int_req), .int_ack(int_ack),
    .inflight(inflight), .ovf(ovf)
  );

  rr_int_coalescer #(.NUM_INT(16), .CNT_WIDTH(4), .TMO_WIDTH(32)) dut4 (
    .clk(clk), .rstn(rstn), .enable(enable), .threshold(threshold4),
    .timeout(timeout4), .ev(ev4), .int_req(int_req4), .int_ack(int_ack4),
    .inflight(inflight4), .ovf(ovf4)
  );

  typedef struct {
    logic [15:0] req, infl, ovf, req4, infl4, ovf4;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_req4 = '0, exp_infl4 = '0, exp_ovf4 = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check_eq("int_req",   64'(int_req),   64'(x.req));
      check_eq("inflight",  64'(inflight),  64'(x.infl));
      check_eq("ovf",       64'(ovf),       64'(x.ovf));
      check_eq("int_req4",  64'(int_req4),  64'(x.req4));
      check_eq("inflight4", 64'(inflight4), 64'(x.infl4));
      check_eq("ovf4",      64'(ovf4),      64'(x.ovf4));
      $display("step @%0t rstn=%b ev=%h ack=%h req=%h infl=%h ovf4=%h",
               $time, rstn, ev, int_ack, int_req, inflight, ovf4);
    end
  end

  task automatic step(input logic r, input logic [15:0] e, input logic [15:0] a,
                      input logic [15:0] xreq, input logic [15:0] xinfl);
    exp_t x;
    rstn    = r;
    ev      = e;
    int_ack = a;
    x.req   = xreq;
    x.infl  = xinfl;
    x.ovf   = 16'h0;
    x.req4  = exp_req4;
    x.infl4 = exp_infl4;
    x.ovf4  = exp_ovf4;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b1; threshold = 16'd4; timeout = 32'd0;
    ev = '0; int_ack = '0;
    threshold4 = 4'd10; timeout4 = 32'd0; ev4 = '0; int_ack4 = '0;

    step(0, 16'h0, 16'h0, 16'h0, 16'h0);
    step(0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Threshold 4 on channel 3; the fourth event also seeds the next batch.
    for (int i = 0; i < 3; i++) step(1, 16'h0008, 16'h0, 16'h0, 16'h0);
    step(1, 16'h0008, 16'h0, 16'h0008, 16'h0008);
    repeat (3) step(1, 16'h0, 16'h0, 16'h0, 16'h0008);
    step(1, 16'h0, 16'h0008, 16'h0, 16'h0);
    for (int i = 0; i < 2; i++) step(1, 16'h0008, 16'h0, 16'h0, 16'h0);
    step(1, 16'h0008, 16'h0, 16'h0008, 16'h0008);
    step(1, 16'h0, 16'h0, 16'h0, 16'h0008);
    step(0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Timeout 10 on channel 0, then ack with empty count returns to IDLE.
    threshold = 16'd100; timeout = 32'd10;
    step(1, 16'h0001, 16'h0, 16'h0, 16'h0);
    repeat (9) step(1, 16'h0, 16'h0, 16'h0, 16'h0);
    step(1, 16'h0, 16'h0, 16'h0001, 16'h0001);
    step(1, 16'h0, 16'h0, 16'h0, 16'h0001);
    step(1, 16'h0, 16'h0001, 16'h0, 16'h0);
    repeat (12) step(1, 16'h0, 16'h0, 16'h0, 16'h0);

    // Threshold 0 acts as 1.
    threshold = 16'd0; timeout = 32'd0;
    step(1, 16'h0040, 16'h0, 16'h0, 16'h0);
    step(1, 16'h0, 16'h0, 16'h0040, 16'h0040);
    step(0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Channel 5: three events while waiting, ack re-enters ACCUM with count 3.
    threshold = 16'd1;
    step(1, 16'h0020, 16'h0, 16'h0, 16'h0);
    step(1, 16'h0, 16'h0, 16'h0020, 16'h0020);
    threshold = 16'd3;
    repeat (3) step(1, 16'h0020, 16'h0, 16'h0, 16'h0020);
    step(1, 16'h0, 16'h0020, 16'h0, 16'h0);
    step(1, 16'h0, 16'h0, 16'h0020, 16'h0020);
    step(0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Channel 2: event on fire edge keeps count 1, ack goes to ACCUM.
    repeat (2) step(1, 16'h0004, 16'h0, 16'h0, 16'h0);
    step(1, 16'h0004, 16'h0, 16'h0004, 16'h0004);
    step(1, 16'h0, 16'h0, 16'h0, 16'h0004);
    step(1, 16'h0, 16'h0004, 16'h0, 16'h0);
    step(1, 16'h0004, 16'h0, 16'h0, 16'h0);
    step(1, 16'h0004, 16'h0, 16'h0004, 16'h0004);
    step(0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Enable low holds off firing; first enabled edge fires.
    threshold = 16'd2; enable = 1'b0;
    repeat (5) step(1, 16'h0200, 16'h0, 16'h0, 16'h0);
    enable = 1'b1;
    step(1, 16'h0, 16'h0, 16'h0200, 16'h0200);
    step(0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Channels 0 and 7 fire together, reset mid-wait, stale ack ignored.
    threshold = 16'd1;
    step(1, 16'h0081, 16'h0, 16'h0, 16'h0);
    step(1, 16'h0, 16'h0, 16'h0081, 16'h0081);
    step(1, 16'h0, 16'h0, 16'h0, 16'h0081);
    step(0, 16'h0, 16'h0, 16'h0, 16'h0);
    step(1, 16'h0, 16'h0081, 16'h0, 16'h0);
    repeat (3) step(1, 16'h0, 16'h0, 16'h0, 16'h0);
    step(1, 16'h0001, 16'h0, 16'h0, 16'h0);
    step(1, 16'h0, 16'h0, 16'h0001, 16'h0001);
    step(0, 16'h0, 16'h0, 16'h0, 16'h0);

    // 4-bit counter saturation with enable low, then fire on enable.
    enable = 1'b0; ev4 = 16'h0002;
    for (int i = 1; i <= 20; i++) begin
      exp_ovf4 = (i >= 16) ? 16'h0002 : 16'h0;
      step(1, 16'h0, 16'h0, 16'h0, 16'h0);
    end
    ev4 = 16'h0; enable = 1'b1;
    exp_req4 = 16'h0002; exp_infl4 = 16'h0002;
    step(1, 16'h0, 16'h0, 16'h0, 16'h0);
    exp_req4 = 16'h0;
    step(1, 16'h0, 16'h0, 16'h0, 16'h0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
